// File: rtl/proc_job_sched_if.sv
// Requester-side bundle of the job scheduler: per-requester job requests
// and the grant/done/err pulses returned to each requester.
interface proc_job_sched_if #(
    parameter int N_REQ = 4,
    parameter int LEN_W = 32
);
    logic [N_REQ-1:0]       req_valid;
    logic [2*N_REQ-1:0]     req_mode;
    logic [8*N_REQ-1:0]     req_val;
    logic [LEN_W*N_REQ-1:0] req_len;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       done;
    logic [N_REQ-1:0]       err;

    modport master (
        output req_valid, req_mode, req_val, req_len,
        input  grant, done, err
    );

    modport slave (
        input  req_valid, req_mode, req_val, req_len,
        output grant, done, err
    );
endinterface

// File: rtl/proc_job_sched.sv
// Round-robin job scheduler: picks one requester, holds its configuration
// stable for the datapath, starts the source and waits for completion/timeout.
module proc_job_sched #(
    parameter int N_REQ      = 4,
    parameter int LEN_W      = 32,
    parameter int TIMEOUT    = 1 << 20,
    parameter int CFG_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    proc_job_sched_if.slave  jobs,
    output logic [1:0]       slv_mode,
    output logic [7:0]       slv_proc_val,
    output logic             src_start,
    output logic [LEN_W-1:0] src_len,
    output logic             proc_flush,
    input  logic             mstr_data_cmplt,
    output logic             busy
);
    localparam int          ID_W    = $clog2(N_REQ);
    localparam int unsigned NR      = N_REQ;
    localparam int          CNT_MAX = (TIMEOUT > CFG_CYCLES) ? TIMEOUT : CFG_CYCLES;
    localparam int          CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARB   = 3'd1;
    localparam logic [2:0] S_CFG   = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_RUN   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ABORT = 3'd6;

    logic [2:0]       state;
    logic [2:0]       state_next;
    logic [CNT_W-1:0] cnt;
    logic [ID_W-1:0]  last;
    logic [ID_W-1:0]  job_id;
    logic [1:0]       job_mode;
    logic [7:0]       job_val;
    logic [LEN_W-1:0] job_len;

    logic [1:0]       mode_a [N_REQ];
    logic [7:0]       val_a  [N_REQ];
    logic [LEN_W-1:0] len_a  [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign mode_a[g] = jobs.req_mode[2*g +: 2];
        assign val_a[g]  = jobs.req_val[8*g +: 8];
        assign len_a[g]  = jobs.req_len[LEN_W*g +: LEN_W];
    end

    logic            win_found;
    logic [ID_W-1:0] win_id;
    logic [ID_W-1:0] scan_idx;
    logic [1:0]      win_mode;
    logic [7:0]      win_val;
    logic [LEN_W-1:0] win_len;
    logic            win_illegal;

    // Scan starts one past the previous winner so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan_idx  = '0;
        for (int unsigned i = 1; i <= NR; i++) begin
            scan_idx = ID_W'((32'(last) + i) % NR);
            if (!win_found && jobs.req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_id    = scan_idx;
            end
        end
    end

    assign win_mode    = mode_a[win_id];
    assign win_val     = val_a[win_id];
    assign win_len     = len_a[win_id];
    assign win_illegal = (win_mode == 2'b00) || (win_mode == 2'b11) || (win_len == '0);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (|jobs.req_valid) state_next = S_ARB;
            S_ARB: begin
                if (!win_found || win_illegal) state_next = S_IDLE;
                else                           state_next = S_CFG;
            end
            S_CFG:   if (cnt == CNT_W'(CFG_CYCLES - 1)) state_next = S_START;
            S_START: state_next = S_RUN;
            S_RUN: begin
                if (mstr_data_cmplt)                  state_next = S_DONE;
                else if (cnt == CNT_W'(TIMEOUT - 1))  state_next = S_ABORT;
            end
            S_DONE:  state_next = S_IDLE;
            S_ABORT: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            last     <= ID_W'(N_REQ - 1);
            job_id   <= '0;
            job_mode <= '0;
            job_val  <= '0;
            job_len  <= '0;
        end else begin
            state <= state_next;
            if (state_next != state)
                cnt <= '0;
            else if (state == S_CFG || state == S_RUN)
                cnt <= cnt + 1'b1;
            if (state == S_ARB && win_found) begin
                last     <= win_id;
                job_id   <= win_id;
                job_mode <= win_mode;
                job_val  <= win_val;
                job_len  <= win_len;
            end
        end
    end

    logic [N_REQ-1:0] grant_vec;
    logic [N_REQ-1:0] done_vec;
    logic [N_REQ-1:0] err_vec;

    // Outputs decode the async-reset state so reset clears them without a clock.
    always_comb begin
        grant_vec    = '0;
        done_vec     = '0;
        err_vec      = '0;
        slv_mode     = '0;
        slv_proc_val = '0;
        src_len      = '0;
        src_start    = 1'b0;
        proc_flush   = 1'b0;
        case (state)
            S_ARB: begin
                if (win_found) begin
                    grant_vec = ONE_HOT0 << win_id;
                    if (win_illegal) err_vec = ONE_HOT0 << win_id;
                end
            end
            S_CFG, S_START, S_RUN: begin
                slv_mode     = job_mode;
                slv_proc_val = job_val;
                src_len      = job_len;
                src_start    = (state == S_START);
            end
            S_DONE:  done_vec = ONE_HOT0 << job_id;
            S_ABORT: begin
                err_vec    = ONE_HOT0 << job_id;
                proc_flush = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy       = (state != S_IDLE);
    assign jobs.grant = grant_vec;
    assign jobs.done  = done_vec;
    assign jobs.err   = err_vec;
endmodule

// File: doc/proc_job_sched.md
# proc_job_sched

Job scheduler in front of the image processing datapath. It arbitrates round-robin between up to `N_REQ` requesters, each asking for one image job with a mode, a processing value and a length. It sequences the datapath for the winner: configure, start the pixel source, wait for completion or timeout, then report. Exactly one job is in flight at a time. The datapath and source never see a configuration change mid-job.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters (2..8).
- `LEN_W`, default 32: job length width, in 32-bit words.
- `TIMEOUT`, default 2^20: RUN-state cycle limit before abort.
- `CFG_CYCLES`, default 4: cycles the configuration is held stable before the source starts.

Ports:
- `clk`, in, 1: the single clock; all logic is rising-edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `req_valid`, in, `N_REQ`: request level per requester; held until granted.
- `req_mode`, in, 2×`N_REQ`: requested mode, slice i. 01 = threshold, 10 = brightness.
- `req_val`, in, 8×`N_REQ`: processing value, slice i.
- `req_len`, in, `LEN_W`×`N_REQ`: job length in words, slice i.
- `grant`, out, `N_REQ`: one-hot, one-cycle pulse on request acceptance.
- `done`, out, `N_REQ`: one-cycle pulse on successful completion.
- `err`, out, `N_REQ`: one-cycle pulse on rejection or timeout.
- `slv_mode`, out, 2: mode to the datapath; 0 when idle.
- `slv_proc_val`, out, 8: value to the datapath.
- `src_start`, out, 1: one-cycle pulse; the source begins streaming.
- `src_len`, out, `LEN_W`: words for the source; valid from CFG onward.
- `proc_flush`, out, 1: one-cycle pulse that forces datapath/source reset on abort.
- `mstr_data_cmplt`, in, 1: completion pulse from the datapath.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- Reset values: all outputs 0; state IDLE; round-robin pointer `last` = `N_REQ`-1; all counters 0.
- States: IDLE, ARB, CFG, START, RUN, DONE, ABORT.
- **IDLE**: if any `req_valid` is set, go to ARB next cycle.
- **ARB** (1 cycle):
  - Winner w is the first set `req_valid` scanning from `last`+1 upward with wrap-around.
  - Assert `grant[w]`, set `last` = w, and latch mode, value and length into job registers.
  - If the mode is 00 or 11, or the length is 0: pulse `err[w]` in the same cycle as `grant[w]` and go to IDLE.
  - Otherwise go to CFG.
  - If `req_valid` dropped to all-zero, return to IDLE with no grant.
- **CFG**:
  - `slv_mode`, `slv_proc_val` and `src_len` are driven from the job registers.
  - Hold for `CFG_CYCLES` cycles (counter 0..`CFG_CYCLES`-1), then go to START.
- **START** (1 cycle): `src_start`=1, then RUN.
- **RUN**:
  - The timeout counter counts up from 0 each cycle.
  - `mstr_data_cmplt`=1 → DONE.
  - Counter reaches `TIMEOUT`-1 without completion → ABORT.
  - Completion and timeout in the same cycle: completion wins.
- **DONE** (1 cycle): pulse `done[w]`; `slv_mode`=0; go to IDLE.
- **ABORT** (1 cycle): pulse `err[w]` and `proc_flush`; `slv_mode`=0; go to IDLE.
- Configuration outputs are stable from CFG through RUN. Changes on `req_*` after grant are ignored.
- A `mstr_data_cmplt` outside RUN is ignored.
- Requesters that are not granted keep waiting. Fairness: a continuously requesting requester is granted within `N_REQ` arbitrations.

## Timing
- Request seen in IDLE at cycle t:
  - ARB/grant at t+1.
  - CFG during t+2 .. t+1+`CFG_CYCLES`.
  - `src_start` at t+2+`CFG_CYCLES`.
  - RUN from t+3+`CFG_CYCLES`.
- `mstr_data_cmplt` sampled at RUN cycle r → `done` at r+1 → IDLE at r+2; the next grant is possible at r+3.
- Back-to-back jobs: minimum `CFG_CYCLES`+5 cycles between consecutive grants when the datapath completes immediately.
- Asynchronous reset at any point forces all outputs to 0 immediately.
  - An in-flight job is dropped without a `done` or `err` pulse.
  - The requester re-requests after reset.

## Test plan
- Single job: req 0, mode 01, val 0x80, len 100 → `grant[0]` at t+1; `src_start` at t+6 (`CFG_CYCLES`=4); `slv_mode`=01 and `slv_proc_val`=0x80 held until completion; inject `mstr_data_cmplt` → `done[0]` next cycle, then `slv_mode`=0.
- Round-robin: reqs 0, 1, 3 held continuously with immediate completion → grant order 0, 1, 3, 0, 1, 3.
- Illegal job: req 2 with mode 11, then len 0 with mode 10 → `grant[2]` and `err[2]` in the same cycle, no `src_start`, no `slv_mode` change.
- Timeout: `TIMEOUT`=64, never complete → `err[w]` and `proc_flush` 64 cycles into RUN; the next request is served normally.
- Simultaneous completion and timeout in the final RUN cycle → `done` pulses, no `err`, no `proc_flush`.
- Reset mid-RUN: deassert `rst_n` → all outputs 0 with no clock edge; after release, IDLE and `last`=`N_REQ`-1, so req 0 is granted first.
